// File: rtl/mips_wb_pkg.sv
// Shared writeback definitions: register-file widths, the queued result entry and the
// hard-wired zero register.
package mips_wb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Parameterised synchronous FIFO with occupancy count and full/empty flags.
// Depth must be a power of two so the pointers wrap by natural overflow.
module wb_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 37,
  localparam int unsigned CntW = $clog2(Depth) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic [CntW-1:0]  count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CntW'(Depth));
  assign count = cnt_q;
  assign rdata = mem_q[rptr_q];

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
    if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: ALU writeback has priority, mul/div results queue in
// a FIFO, and a pending-destination scoreboard feeds the hazard unit.
// Optional macro WB_MD_BYPASS_EN lets a result skip the empty FIFO when the port is idle.
module wb_write_arbiter
  import mips_wb_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = mips_wb_pkg::DATA_W,
  parameter int unsigned ADDR_W = mips_wb_pkg::ADDR_W,
  localparam int unsigned CntW  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_wb_valid,
  input  logic [ADDR_W-1:0] alu_wb_addr,
  input  logic [DATA_W-1:0] alu_wb_data,
  input  logic              md_issue,
  input  logic [ADDR_W-1:0] md_issue_addr,
  input  logic              md_valid,
  output logic              md_ready,
  input  logic [ADDR_W-1:0] md_addr,
  input  logic [DATA_W-1:0] md_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_a3,
  output logic [DATA_W-1:0] rf_wd,
  output logic [31:0]       pend_mask,
  output logic [CntW-1:0]   fifo_cnt,
  output logic              waw_err
);

  localparam logic [ADDR_W-1:0] Zero = ADDR_W'(REG_ZERO);

  logic [ADDR_W+DATA_W-1:0] head;
  logic [ADDR_W-1:0]        head_addr;
  logic [DATA_W-1:0]        head_data;
  logic                     fifo_full, fifo_empty;
  logic                     fifo_push, fifo_pop;
  logic                     alu_we, md_byp;
  logic                     md_wr;
  logic [ADDR_W-1:0]        md_wr_addr;
  logic [DATA_W-1:0]        md_wr_data;
  logic [31:0]              set_mask, clr_mask;
  logic [31:0]              pend_q, pend_d;
  logic                     waw_q, waw_d;

  assign head_addr = head[ADDR_W+DATA_W-1:DATA_W];
  assign head_data = head[DATA_W-1:0];

  // Writes to $0 are discarded so they never block the FIFO head.
  assign alu_we = rst && alu_wb_valid && (alu_wb_addr != Zero);

`ifdef WB_MD_BYPASS_EN
  assign md_byp = rst && fifo_empty && !alu_we && md_valid;
`else
  assign md_byp = 1'b0;
`endif

  assign fifo_pop  = rst && !alu_we && !fifo_empty;
  assign md_ready  = rst && (!fifo_full || fifo_pop);
  assign fifo_push = md_valid && md_ready && !md_byp;

  wb_fifo #(
    .Depth (DEPTH),
    .Width (ADDR_W + DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata ({md_addr, md_data}),
    .pop   (fifo_pop),
    .rdata (head),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    md_wr      = 1'b0;
    md_wr_addr = '0;
    md_wr_data = '0;
    if (fifo_pop) begin
      md_wr      = 1'b1;
      md_wr_addr = head_addr;
      md_wr_data = head_data;
    end else if (md_byp) begin
      md_wr      = 1'b1;
      md_wr_addr = md_addr;
      md_wr_data = md_data;
    end
  end

  always_comb begin
    rf_we = 1'b0;
    rf_a3 = '0;
    rf_wd = '0;
    if (alu_we) begin
      rf_we = 1'b1;
      rf_a3 = alu_wb_addr;
      rf_wd = alu_wb_data;
    end else if (md_wr && (md_wr_addr != Zero)) begin
      rf_we = 1'b1;
      rf_a3 = md_wr_addr;
      rf_wd = md_wr_data;
    end
  end

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (md_issue && (md_issue_addr != Zero)) set_mask[md_issue_addr] = 1'b1;
    if (md_wr && (md_wr_addr != Zero))       clr_mask[md_wr_addr]    = 1'b1;
    // Set after clear: a re-issue to a retiring register keeps it pending.
    pend_d = (pend_q & ~clr_mask) | set_mask;
    waw_d  = waw_q | (alu_we && pend_q[alu_wb_addr]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= '0;
      waw_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      waw_q  <= waw_d;
    end
  end

  assign pend_mask = pend_q;
  assign waw_err   = waw_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: directed scenarios with literal expectations,
// then randomized traffic against a queue-based reference model.
module tb_wb_write_arbiter;
  import mips_wb_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              alu_wb_valid;
  logic [ADDR_W-1:0] alu_wb_addr;
  logic [DATA_W-1:0] alu_wb_data;
  logic              md_issue;
  logic [ADDR_W-1:0] md_issue_addr;
  logic              md_valid;
  logic              md_ready;
  logic [ADDR_W-1:0] md_addr;
  logic [DATA_W-1:0] md_data;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_a3;
  logic [DATA_W-1:0] rf_wd;
  logic [31:0]       pend_mask;
  logic [CW-1:0]     fifo_cnt;
  logic              waw_err;

  wb_write_arbiter #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .alu_wb_valid  (alu_wb_valid),
    .alu_wb_addr   (alu_wb_addr),
    .alu_wb_data   (alu_wb_data),
    .md_issue      (md_issue),
    .md_issue_addr (md_issue_addr),
    .md_valid      (md_valid),
    .md_ready      (md_ready),
    .md_addr       (md_addr),
    .md_data       (md_data),
    .rf_we         (rf_we),
    .rf_a3         (rf_a3),
    .rf_wd         (rf_wd),
    .pend_mask     (pend_mask),
    .fifo_cnt      (fifo_cnt),
    .waw_err       (waw_err)
  );

  always #5 clk = ~clk;

  // Reference model: queued results, pending set, sticky error.
  wb_entry_t   q[$];
  logic [31:0] m_pend;
  logic        m_waw;

  // Per-cycle expectations, computed at negedge and applied at the following posedge.
  logic              e_alu, e_byp, e_pop, e_rdy, e_push, e_mdw;
  logic [ADDR_W-1:0] e_mda;
  logic [DATA_W-1:0] e_mdd;
  logic              e_we;
  logic [ADDR_W-1:0] e_a3;
  logic [DATA_W-1:0] e_wd;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (!rst) begin
      q.delete();
      m_pend = '0;
      m_waw  = 1'b0;
    end
    e_alu = rst && alu_wb_valid && (alu_wb_addr != 0);
    e_byp = 1'b0;
`ifdef WB_MD_BYPASS_EN
    e_byp = rst && (q.size() == 0) && !e_alu && md_valid;
`endif
    e_pop  = rst && !e_alu && (q.size() > 0);
    e_rdy  = rst && ((q.size() < DEPTH) || e_pop);
    e_push = md_valid && e_rdy && !e_byp;
    e_mdw  = e_pop || e_byp;
    e_mda  = '0;
    e_mdd  = '0;
    if (e_pop) begin
      e_mda = q[0].addr;
      e_mdd = q[0].data;
    end else if (e_byp) begin
      e_mda = md_addr;
      e_mdd = md_data;
    end
    e_we = 1'b0;
    e_a3 = '0;
    e_wd = '0;
    if (e_alu) begin
      e_we = 1'b1;
      e_a3 = alu_wb_addr;
      e_wd = alu_wb_data;
    end else if (e_mdw && e_mda != 0) begin
      e_we = 1'b1;
      e_a3 = e_mda;
      e_wd = e_mdd;
    end
    chk("rf_we", rf_we, e_we);
    chk("rf_a3", rf_a3, e_a3);
    chk("rf_wd", rf_wd, e_wd);
    chk("md_ready", md_ready, e_rdy);
    chk("fifo_cnt", fifo_cnt, q.size());
    chk("pend_mask", pend_mask, m_pend);
    chk("waw_err", waw_err, m_waw);
  endtask

  task automatic adv();
    wb_entry_t ent;
    @(posedge clk);
    if (rst) begin
      if (e_alu && m_pend[alu_wb_addr]) m_waw = 1'b1;
      if (e_mdw && e_mda != 0) m_pend[e_mda] = 1'b0;
      if (e_pop) void'(q.pop_front());
      if (e_push) begin
        ent.addr = md_addr;
        ent.data = md_data;
        q.push_back(ent);
      end
      if (md_issue && md_issue_addr != 0) m_pend[md_issue_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    alu_wb_valid  = 1'b0;
    alu_wb_addr   = '0;
    alu_wb_data   = '0;
    md_issue      = 1'b0;
    md_issue_addr = '0;
    md_valid      = 1'b0;
    md_addr       = '0;
    md_data       = '0;
  endtask

  initial begin
    logic acc;
    int   rst_left;
    rst = 1'b0;
    q.delete();
    m_pend = '0;
    m_waw  = 1'b0;
    idle_inputs();

    // Reset held with a result offered.
    md_valid = 1'b1;
    md_addr  = 5'd7;
    md_data  = 32'hAAAA_5555;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_rf_we", rf_we, 1'b0);
      chk("rst_md_ready", md_ready, 1'b0);
      chk("rst_pend", pend_mask, 32'h0);
      adv();
    end
    rst = 1'b1;
    idle_inputs();
    tick();
    chk("rel_md_ready", md_ready, 1'b1);
    chk("rel_fifo_cnt", fifo_cnt, 0);
    adv();

    // ALU only.
    alu_wb_valid = 1'b1;
    alu_wb_addr  = 5'd5;
    alu_wb_data  = 32'hDEAD_BEEF;
    tick();
    chk("alu_we", rf_we, 1'b1);
    chk("alu_a3", rf_a3, 5);
    chk("alu_wd", rf_wd, 32'hDEAD_BEEF);
    adv();
    alu_wb_addr = 5'd0;
    tick();
    chk("alu_r0_we", rf_we, 1'b0);
    adv();
    idle_inputs();

    // Contention: result for $8 waits behind two ALU writes to $3.
    md_issue      = 1'b1;
    md_issue_addr = 5'd8;
    tick();
    adv();
    md_issue     = 1'b0;
    alu_wb_valid = 1'b1;
    alu_wb_addr  = 5'd3;
    alu_wb_data  = 32'h0000_0333;
    md_valid     = 1'b1;
    md_addr      = 5'd8;
    md_data      = 32'h1234_5678;
    tick();
    chk("cont_rdy", md_ready, 1'b1);
    chk("cont_a3_alu", rf_a3, 3);
    adv();
    md_valid = 1'b0;
    tick();
    chk("cont_cnt", fifo_cnt, 1);
    chk("cont_pend8", pend_mask[8], 1'b1);
    adv();
    alu_wb_valid = 1'b0;
    tick();
    chk("cont_md_a3", rf_a3, 8);
    chk("cont_md_wd", rf_wd, 32'h1234_5678);
    adv();
    tick();
    chk("cont_pend8_clr", pend_mask[8], 1'b0);
    chk("cont_cnt0", fifo_cnt, 0);
    adv();

    // Full FIFO and back-pressure, ALU busy throughout the offers.
    alu_wb_valid = 1'b1;
    alu_wb_addr  = 5'd3;
    for (int i = 0; i < 3; i++) begin
      md_valid = 1'b1;
      md_addr  = ADDR_W'(10 + i);
      md_data  = 32'(i + 1);
      tick();
      chk("full_rdy", md_ready, (i < 2) ? 1'b1 : 1'b0);
      if (i == 2) chk("full_cnt", fifo_cnt, 2);
      adv();
    end
    alu_wb_valid = 1'b0;
    tick();
    chk("full_pop_rdy", md_ready, 1'b1);
    chk("order0", rf_a3, 10);
    adv();
    md_valid = 1'b0;
    tick();
    chk("full_cnt_hold", fifo_cnt, 2);
    chk("order1", rf_a3, 11);
    adv();
    tick();
    chk("order2", rf_a3, 12);
    chk("order2_wd", rf_wd, 3);
    adv();
    tick();
    chk("drained_we", rf_we, 1'b0);
    adv();

    // Scoreboard collision: re-issue to $9 in the cycle its result retires.
    md_issue      = 1'b1;
    md_issue_addr = 5'd9;
    tick();
    adv();
    md_issue = 1'b0;
    md_valid = 1'b1;
    md_addr  = 5'd9;
    md_data  = 32'h99;
`ifdef WB_MD_BYPASS_EN
    md_issue = 1'b1;
`else
    tick();
    adv();
    md_valid = 1'b0;
    md_issue = 1'b1;
`endif
    tick();
    chk("coll_a3", rf_a3, 9);
    adv();
    idle_inputs();
    tick();
    chk("coll_pend9", pend_mask[9], 1'b1);
    adv();
    alu_wb_valid = 1'b1;
    alu_wb_addr  = 5'd9;
    alu_wb_data  = 32'h0BAD;
    tick();
    chk("waw_alu_we", rf_we, 1'b1);
    adv();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("waw_sticky", waw_err, 1'b1);
      adv();
    end

    // Direct path with empty FIFO and idle ALU.
    md_valid = 1'b1;
    md_addr  = 5'd4;
    md_data  = 32'h55;
    tick();
`ifdef WB_MD_BYPASS_EN
    chk("byp_we", rf_we, 1'b1);
    chk("byp_a3", rf_a3, 4);
    adv();
    md_valid = 1'b0;
    tick();
    chk("byp_cnt", fifo_cnt, 0);
    adv();
`else
    chk("nobyp_we", rf_we, 1'b0);
    adv();
    md_valid = 1'b0;
    tick();
    chk("nobyp_cnt", fifo_cnt, 1);
    chk("nobyp_a3", rf_a3, 4);
    chk("nobyp_wd", rf_wd, 32'h55);
    adv();
`endif

    // Randomized traffic with occasional asynchronous resets.
    idle_inputs();
    rst_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (rst_left > 0) begin
        rst_left--;
        rst = (rst_left == 0);
      end else if ($urandom_range(0, 299) == 0) begin
        rst      = 1'b0;
        rst_left = $urandom_range(1, 3);
      end
      alu_wb_valid  = ($urandom_range(0, 99) < 45);
      alu_wb_addr   = ADDR_W'($urandom_range(0, 11));
      alu_wb_data   = $urandom;
      md_issue      = ($urandom_range(0, 99) < 30);
      md_issue_addr = ADDR_W'($urandom_range(0, 11));
      // Source holds an offered result stable until it is accepted.
      if (!md_valid && $urandom_range(0, 2) != 0) begin
        md_valid = 1'b1;
        md_addr  = ADDR_W'($urandom_range(0, 11));
        md_data  = $urandom;
      end
      tick();
      acc = md_valid && (e_push || e_byp);
      adv();
      if (acc) md_valid = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Writer side of the 32x32 register file's single write port (A3/WD/WE).
- Merges two result sources:
  - the in-order ALU/load writeback from MEM/WB;
  - out-of-order results from the multi-cycle multiply/divide unit.
- The ALU has priority. Mul/div results queue in a small FIFO until the port is free.
- Keeps a pending-destination scoreboard for the hazard unit.

Parameters:
- DEPTH, 2: mul/div result FIFO entries (power of two, at least 2).
- DATA_W, 32: register data width.
- ADDR_W, 5: register address width.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- alu_wb_valid  in  1  MEM/WB result valid this cycle.
- alu_wb_addr  in  ADDR_W  MEM/WB destination.
- alu_wb_data  in  DATA_W  MEM/WB result.
- md_issue  in  1  mul/div op issued this cycle.
- md_issue_addr  in  ADDR_W  destination of the issued op.
- md_valid  in  1  mul/div result offered.
- md_ready  out  1  FIFO can accept a result.
- md_addr  in  ADDR_W  mul/div result destination.
- md_data  in  DATA_W  mul/div result.
- rf_we  out  1  to register file WE.
- rf_a3  out  ADDR_W  to register file A3.
- rf_wd  out  DATA_W  to register file WD.
- pend_mask  out  32  bit i set means register i awaits a mul/div result.
- fifo_cnt  out  $clog2(DEPTH)+1  current FIFO occupancy.
- waw_err  out  1  sticky; an ALU write hit a pending register.

Behaviour:
- Reset (rst low, asynchronous):
  - FIFO empties, fifo_cnt=0, pend_mask=0, waw_err=0.
  - rf_we is forced 0 while rst is low; rf_a3=0, rf_wd=0.
  - md_ready=0 while rst is low, 1 after release.
  - A reset mid-queue discards queued results without writing them.
- Write-port selection (combinational from current inputs and state; the register file samples on negedge, so the write lands in the same cycle):
  - Priority 1: alu_wb_valid && alu_wb_addr!=0 gives rf_we=1, rf_a3=alu_wb_addr, rf_wd=alu_wb_data.
  - Priority 2: FIFO non-empty gives rf_we=1 with the head entry; the head pops at posedge.
  - Otherwise rf_we=0, rf_a3=0, rf_wd=0.
- Register $0:
  - An ALU write to $0 is dropped, so the FIFO head may use the port that cycle.
  - A mul/div result to $0 is accepted and popped but never asserts rf_we.
- FIFO rules:
  - md_ready = (fifo_cnt<DEPTH), with one exception: when full and popping this cycle, md_ready is 1 (push and pop in the same cycle are allowed).
  - Push occurs when md_valid && md_ready. A push and a pop in one cycle leave fifo_cnt unchanged.
  - Read and write pointers wrap modulo DEPTH. Entries retire strictly in arrival order.
  - md_valid while md_ready=0 is not an accept: the source holds md_addr and md_data stable.
- Scoreboard:
  - md_issue sets pend_mask[md_issue_addr] at posedge.
  - Writing a mul/div result to the register file clears that bit.
  - If a set and a clear hit the same bit in one cycle, set wins.
  - Bit 0 is never set.
- waw_err: set at posedge when an ALU write with rf_we=1 targets a register whose pend_mask bit is 1. It clears only on reset.
- Latency: an ALU result is written with 0 cycles added. A mul/div result is written no earlier than the cycle after acceptance, unless the bypass feature below is compiled in.

Optional Feature:
- Macro: WB_MD_BYPASS_EN.
- Defined:
  - When the FIFO is empty, no valid ALU write is present, and md_valid=1, the result goes straight to rf_*.
  - It is not enqueued, and its pend_mask bit clears at that posedge.
  - md_ready=1 in that cycle.
- Undefined: every mul/div result is enqueued first, giving a minimum of 1 cycle from acceptance to write.

Decomposition:
- Package mips_wb_pkg holds:
  - DATA_W and ADDR_W constants;
  - the wb_entry_t struct {addr, data};
  - the REG_ZERO constant.
- Sub-module wb_fifo is a parameterised synchronous FIFO with count, full and empty, reused elsewhere. Scoreboard and arbitration logic stay in the top.

Test Plan:
- Reset sequence: hold rst low 3 cycles with md_valid=1 -> rf_we=0, md_ready=0, pend_mask=0; after release md_ready=1, fifo_cnt=0.
- ALU only: alu_wb_valid=1, addr=5, data=0xDEADBEEF -> rf_we=1, rf_a3=5, rf_wd=0xDEADBEEF in the same cycle; addr=0 gives rf_we=0.
- Contention: issue to $8, then offer md result ($8, 0x12345678) while ALU writes $3 for 2 cycles -> FIFO holds it with fifo_cnt=1; written the first cycle ALU is idle; pend_mask[8] clears at that posedge.
- Full and back-pressure (DEPTH=2): offer 3 results while ALU is busy -> md_ready=0 after 2 accepts. The third result is accepted in the first pop cycle. Write order matches arrival order.
- Scoreboard collision: md_issue to $9 in the same cycle $9's earlier result retires -> pend_mask[9] stays 1. A later ALU write to $9 sets waw_err=1, which stays set until reset.
- Bypass (WB_MD_BYPASS_EN): FIFO empty, ALU idle, md_valid with ($4, 0x55) -> rf_we=1 same cycle, fifo_cnt stays 0. Without the macro: fifo_cnt=1, and the write occurs the next cycle.
